// File: rtl/mips_mult_div.sv
// HI/LO multiply-divide unit: iterative MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
// Optional macro MIPS_MULT_DIV_FAST_MULT_EN selects a single-cycle combinational multiply.
module mips_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_lo_q, neg_lo_d;
    logic                   neg_hi_q, neg_hi_d;
    logic                   dz_q, dz_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   op_signed;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         rem_shift;
    logic [WIDTH:0]         rem_diff;
    logic [2*WIDTH-1:0]     prod_signed;
    logic [WIDTH-1:0]       quot_signed, rem_signed;

    // Signed ops run on magnitudes; signs are reapplied when the result is written.
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff  = rem_shift - {1'b0, opnd_q};

    assign prod_signed = neg_lo_q ? -acc_q : acc_q;
    assign quot_signed = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_signed  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            cnt_d    = '0;
                            is_div_d = 1'b0;
                            neg_lo_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = 1'b0;
                            dz_d     = 1'b0;
`ifdef MIPS_MULT_DIV_FAST_MULT_EN
                            acc_d    = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                            opnd_d   = mag_a;
                            state_d  = ST_FIN;
`else
                            acc_d    = {{WIDTH{1'b0}}, mag_b};
                            opnd_d   = mag_a;
                            state_d  = ST_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, mag_a};
                            opnd_d   = mag_b;
                            is_div_d = 1'b1;
                            neg_lo_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = op_signed && a[WIDTH-1];
                            dz_d     = (b == '0);
                            state_d  = ST_DIV;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FIN;
            end
            ST_DIV: begin
                if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FIN;
            end
            ST_FIN: begin
                if (is_div_q) begin
                    // Divide by zero leaves the dividend in HI, which the signed remainder path already yields.
                    lo_d = dz_q ? '1 : quot_signed;
                    hi_d = rem_signed;
                end else begin
                    {hi_d, lo_d} = prod_signed;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mult_div.sv
// Bench for mips_mult_div: cycle-level arithmetic reference model plus directed vectors.
module tb_mips_mult_div;

`ifdef MIPS_MULT_DIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    mips_mult_div #(.WIDTH(32)) dut (
        .CLK(CLK), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remaining-cycle count and pending result, computed with plain arithmetic.
    int          m_left;
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge CLK) begin
        longint sa, sb, q, r;
        logic [63:0] t;
        if (!rst) begin
            m_left = 0; m_hi = 0; m_lo = 0; m_done = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                case (op)
                    3'b000: begin t = sa * sb; {p_hi, p_lo} = t; m_left = MUL_LAT; end
                    3'b001: begin t = {32'b0, a} * {32'b0, b}; {p_hi, p_lo} = t; m_left = MUL_LAT; end
                    3'b010: begin
                        if (b == 0) begin p_hi = a; p_lo = 32'hFFFF_FFFF; end
                        else begin
                            q = sa / sb; r = sa % sb;
                            t = q; p_lo = t[31:0];
                            t = r; p_hi = t[31:0];
                        end
                        m_left = DIV_LAT;
                    end
                    3'b011: begin
                        if (b == 0) begin p_hi = a; p_lo = 32'hFFFF_FFFF; end
                        else begin p_lo = a / b; p_hi = a % b; end
                        m_left = DIV_LAT;
                    end
                    3'b100: m_hi = a;
                    3'b101: m_lo = a;
                    default: ;
                endcase
            end
        end
        m_busy = (m_left > 0);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            if (done && busy) chk("done_with_busy", 32'd1, 32'd0);
        end
    end

    // Entered and left at posedge+2; operands are scrambled right after the accept edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input string nm);
        int cyc;
        int busy_cnt;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge CLK); #2;
        start = 1'b0; a = ~av; b = bv ^ 32'h5A5A_0F0F;
        cyc = 0; busy_cnt = 0;
        while (cyc < 100) begin
            @(negedge CLK);
            if (done) break;
            if (busy) busy_cnt++;
            cyc++;
        end
        chk({nm, "_done_seen"}, {31'b0, done}, 32'd1);
        chk({nm, "_busy_cycles"}, busy_cnt, lat);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        @(posedge CLK); #2;
    endtask

    initial begin
        int dcount;
        rst = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        @(posedge CLK); #2;
        chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b1;
        @(posedge CLK); #2;

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, "multu_max");
        run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, "mult_neg3x7");
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT, "mult_minmin");
        run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_neg7_2");
        run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT, "div_7_neg2");
        run_op(3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV_LAT, "divu_by0");
        run_op(3'b010, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, DIV_LAT, "div_neg_by0");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, "div_ovf");
        run_op(3'b011, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, DIV_LAT, "divu_big");

        // MTHI then MTLO on consecutive edges, then a no-op code
        start = 1'b1; op = 3'b100; a = 32'h1234_5678;
        @(posedge CLK); #2;
        op = 3'b101; a = 32'h9ABC_DEF0;
        @(posedge CLK); #2;
        op = 3'b110; a = 32'hDEAD_BEEF;
        @(posedge CLK); #2;
        start = 1'b0;
        chk("mt_hi", hi, 32'h1234_5678);
        chk("mt_lo", lo, 32'h9ABC_DEF0);
        chk("mt_busy", {31'b0, busy}, 32'd0);
        chk("mt_done", {31'b0, done}, 32'd0);

        // Start while busy must be ignored and mid-op operand changes must not matter
        start = 1'b1; op = 3'b011; a = 32'd50; b = 32'd7;
        @(posedge CLK); #2;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd3;
        @(posedge CLK); #2;
        start = 1'b0; a = 32'hCAFE_F00D; b = 32'd0;
        dcount = 0;
        while (dcount < 100 && !done) begin @(negedge CLK); dcount++; end
        chk("ign_done_seen", {31'b0, done}, 32'd1);
        chk("ign_lo", lo, 32'd7);
        chk("ign_hi", hi, 32'd1);
        @(posedge CLK); #2;
        chk("ign_not_queued", {31'b0, busy}, 32'd0);

        // Reset mid-operation aborts without a result
        start = 1'b1; op = 3'b011; a = 32'd50; b = 32'd7;
        @(posedge CLK); #2;
        start = 1'b0;
        repeat (14) @(posedge CLK);
        #2;
        rst = 1'b0;
        @(posedge CLK); #2;
        rst = 1'b1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        @(posedge CLK); #2;
        run_op(3'b001, 32'd3, 32'd3, 32'd0, 32'd9, MUL_LAT, "multu_after_abort");

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_mult_div.md
Name: mips_mult_div

Overview:
- HI/LO multiply-divide unit downstream of the register file.
- Operands come from register-file read ports DataOut1 (rs) and DataOut2 (rt).
- Executes MULT, MULTU, DIV, DIVU iteratively (one bit per cycle) and MTHI, MTLO in one cycle.
- Holds the architectural HI/LO registers; the execute stage reads them for MFHI/MFLO and stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low, sampled on rising CLK.
- start  input  1  request; accepted on a rising edge when start=1 and busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  input  32  rt operand (divisor / multiplier).
- busy  output  1  operation in progress; new start ignored.
- done  output  1  one-cycle pulse; hi/lo already hold the new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (rst=0 at an edge): hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter 0. Applies mid-operation: the operation is aborted and no partial result is written.
- States: IDLE, MUL, DIV, FIN.
- IDLE: accept at edge k. a, b and op are latched; the block never samples a or b after the accept edge.
  - MULT/MULTU -> MUL; DIV/DIVU -> DIV; busy=1 after edge k.
  - MTHI: hi<=a at edge k. MTLO: lo<=a at edge k. State stays IDLE, busy stays 0, no done pulse.
  - op 110/111: nothing changes.
- Signed ops (MULT, DIV): operands are converted to magnitudes at accept; the sign is restored in FIN.
- MUL: 32 shift-add iterations, edges k+1..k+32. 64-bit product {hi,lo} = a*b (unsigned or two's-complement signed).
- DIV: 32 restoring-division iterations, edges k+1..k+32. lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Counter counts 0..31; the iteration at count 31 moves the state to FIN.
- FIN (edge k+33): hi/lo written, done=1 for the following cycle, busy=0, state -> IDLE.
  - Total: busy high for 33 cycles; earliest next accept at edge k+34.
- hi/lo hold their old values throughout MUL/DIV.
- start while busy=1: ignored entirely. It is not queued and has no effect on the operation in flight.
- Divide by zero (b=0, DIV or DIVU): lo=0xFFFFFFFF, hi=a. Same latency; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- done is registered, deasserts after one cycle, and is never high while busy=1.

Optional Feature:
- Macro MIPS_MULT_DIV_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle combinational 32x32 multiply.
  - Accept at edge k; hi/lo written at edge k+1; done=1 after k+1; busy high one cycle only.
  - DIV/DIVU unchanged.
- Undefined: MULT/MULTU use the 33-cycle iterative path. No combinational multiplier is synthesised.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 busy cycles done=1, hi=0xFFFFFFFE, lo=0x00000001. With MIPS_MULT_DIV_FAST_MULT_EN: same values after 1 cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive edges -> hi=0x12345678, lo=0x9ABCDEF0; busy and done stay 0.
- Start DIVU 50/7, then pulse start with MULTU 3*3 at cycle 10 and change a/b mid-operation -> lo=7, hi=1 at done; second request ignored.
- Start DIVU 50/7, then drive rst=0 at cycle 15 -> next cycle hi=0, lo=0, busy=0, done=0, and no done pulse ever follows.
